// File: rtl/tx_frame_scheduler.sv
// Frame-level sequencer for the OFDM Tx symbol mapper: drives enable, modulation/spreading
// settings and ready_frame, swapping configuration only on frame boundaries.
module tx_frame_scheduler #(
    parameter int FRAME_SYMS = 50,
    parameter int N_PREAMB   = 2,
    parameter int LEVEL_W    = 12,
    parameter int SYM_THRESH = 96
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_cfg_valid,
    output logic               o_cfg_ready,
    input  logic [2:0]         i_cfg_mod,
    input  logic [3:0]         i_cfg_ss,
    input  logic [15:0]        i_cfg_nframes,
    output logic               o_cfg_err,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [LEVEL_W-1:0] i_buf_level,
    input  logic               i_map_oeop,
    input  logic               i_map_req,
    output logic               o_map_enable,
    output logic [2:0]         o_map_index_M,
    output logic [3:0]         o_map_index_ss,
    output logic               o_map_ready_frame,
    output logic               o_busy,
    output logic [15:0]        o_frame_cnt,
    output logic               o_underrun,
    output logic               o_done
);
    localparam int SYM_W = $clog2(FRAME_SYMS);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_PREAMB, S_DATA, S_DRAIN} state_t;
    state_t r_state, w_next;

    logic [SYM_W-1:0] r_sym_cnt;
    logic [15:0]      r_frame_cnt, r_nframes, r_shd_nframes;
    logic [2:0]       r_mod, r_shd_mod;
    logic [3:0]       r_ss, r_shd_ss;
    logic             r_shd_full, r_stop_pend, r_map_en, r_rdy, r_underrun, r_done, r_cfg_err;

    logic w_mod_ok, w_cfg_fire, w_sym_end, w_frame_end, w_pre_end, w_buf_ok, w_last_frame, w_go;

    assign w_mod_ok     = (i_cfg_mod == 3'd1) || (i_cfg_mod == 3'd2) ||
                          (i_cfg_mod == 3'd4) || (i_cfg_mod == 3'd6);
    assign w_cfg_fire   = i_cfg_valid && !r_shd_full;
    assign w_sym_end    = i_map_oeop && r_map_en;
    assign w_frame_end  = w_sym_end && (r_sym_cnt == SYM_W'(FRAME_SYMS - 1));
    assign w_pre_end    = w_sym_end && (r_sym_cnt == SYM_W'(N_PREAMB - 1));
    assign w_buf_ok     = i_buf_level >= LEVEL_W'(SYM_THRESH);
    // Compare in 17 bits so a saturated frame counter cannot alias onto nframes.
    assign w_last_frame = (r_nframes != '0) &&
                          (({1'b0, r_frame_cnt} + 17'd1) == {1'b0, r_nframes});
    assign w_go         = (r_state == S_IDLE) && i_start;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_ARM;
            S_ARM:    if (i_stop) w_next = S_IDLE;
                      else if (w_buf_ok) w_next = S_PREAMB;
            S_PREAMB: if (w_pre_end) w_next = S_DATA;
            S_DATA:   if (w_frame_end)
                          w_next = (r_stop_pend || i_stop || w_last_frame) ? S_DRAIN : S_PREAMB;
            S_DRAIN:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_sym_cnt     <= '0;
            r_frame_cnt   <= '0;
            r_nframes     <= '0;
            r_shd_nframes <= '0;
            r_mod         <= '0;
            r_shd_mod     <= '0;
            r_ss          <= 4'd1;
            r_shd_ss      <= 4'd1;
            r_shd_full    <= 1'b0;
            r_stop_pend   <= 1'b0;
            r_map_en      <= 1'b0;
            r_rdy         <= 1'b0;
            r_underrun    <= 1'b0;
            r_done        <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_map_en  <= (w_next == S_PREAMB) || (w_next == S_DATA);
            r_done    <= (w_next == S_IDLE) && (r_state != S_IDLE);
            r_cfg_err <= w_cfg_fire && !w_mod_ok;

            // ready_frame is latched per symbol: at DATA entry and on every symbol end.
            if (w_next != S_DATA)
                r_rdy <= 1'b0;
            else if (r_state != S_DATA || w_sym_end)
                r_rdy <= w_buf_ok;

            if (w_go) begin
                r_sym_cnt   <= '0;
                r_frame_cnt <= '0;
            end else if (w_frame_end) begin
                r_sym_cnt <= '0;
                if (r_frame_cnt != 16'hFFFF)
                    r_frame_cnt <= r_frame_cnt + 16'd1;
            end else if (w_sym_end) begin
                r_sym_cnt <= r_sym_cnt + SYM_W'(1);
            end

            if (w_next == S_IDLE)
                r_stop_pend <= 1'b0;
            else if (i_stop && r_state != S_IDLE)
                r_stop_pend <= 1'b1;

            if (w_go)
                r_underrun <= 1'b0;
            else if (i_map_req && i_buf_level == '0)
                r_underrun <= 1'b1;

            if (w_cfg_fire && w_mod_ok) begin
                r_shd_full    <= 1'b1;
                r_shd_mod     <= i_cfg_mod;
                r_shd_ss      <= (i_cfg_ss == 4'd0) ? 4'd1 : i_cfg_ss;
                r_shd_nframes <= i_cfg_nframes;
            end else if (r_shd_full && (r_state == S_IDLE || w_frame_end)) begin
                r_shd_full <= 1'b0;
                r_mod      <= r_shd_mod;
                r_ss       <= r_shd_ss;
                r_nframes  <= r_shd_nframes;
            end
        end
    end

    assign o_cfg_ready       = !r_shd_full;
    assign o_cfg_err         = r_cfg_err;
    assign o_map_enable      = r_map_en;
    assign o_map_index_M     = r_mod;
    assign o_map_index_ss    = r_ss;
    assign o_map_ready_frame = r_rdy;
    assign o_busy            = (r_state != S_IDLE);
    assign o_frame_cnt       = r_frame_cnt;
    assign o_underrun        = r_underrun;
    assign o_done            = r_done;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Scoreboard bench for tx_frame_scheduler: a symbol/frame-level model queues the expected
// per-symbol settings, done pulses and cfg errors; a negedge monitor checks them.
module tb_tx_frame_scheduler;
    localparam int FS = 50;
    localparam int NP = 2;
    localparam int LW = 12;
    localparam int TH = 96;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cfg_valid, i_start, i_stop, i_map_oeop, i_map_req;
    logic [2:0]    i_cfg_mod;
    logic [3:0]    i_cfg_ss;
    logic [15:0]   i_cfg_nframes;
    logic [LW-1:0] i_buf_level;
    logic          o_cfg_ready, o_cfg_err, o_map_enable, o_map_ready_frame;
    logic          o_busy, o_underrun, o_done;
    logic [2:0]    o_map_index_M;
    logic [3:0]    o_map_index_ss;
    logic [15:0]   o_frame_cnt;

    tx_frame_scheduler #(.FRAME_SYMS(FS), .N_PREAMB(NP), .LEVEL_W(LW), .SYM_THRESH(TH)) dut (
        .clk(clk), .rst(rst),
        .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready), .i_cfg_mod(i_cfg_mod),
        .i_cfg_ss(i_cfg_ss), .i_cfg_nframes(i_cfg_nframes), .o_cfg_err(o_cfg_err),
        .i_start(i_start), .i_stop(i_stop), .i_buf_level(i_buf_level),
        .i_map_oeop(i_map_oeop), .i_map_req(i_map_req),
        .o_map_enable(o_map_enable), .o_map_index_M(o_map_index_M),
        .o_map_index_ss(o_map_index_ss), .o_map_ready_frame(o_map_ready_frame),
        .o_busy(o_busy), .o_frame_cnt(o_frame_cnt), .o_underrun(o_underrun), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rf;
        bit [2:0] mod;
        bit [3:0] ss;
    } sym_t;

    sym_t exp_sym[$];
    int   exp_done[$];
    int   exp_err[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: position in the frame, active and pending settings.
    int       m_sym, m_frame, m_nf, m_lvl, m_shd_nf;
    bit [2:0] m_mod, m_shd_mod;
    bit [3:0] m_ss, m_shd_ss;
    bit       m_shd, m_stop, m_run;
    bit       fin;
    sym_t     mon_e;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mod = 3'd0; m_ss = 4'd1; m_nf = 0; m_shd = 1'b0; m_run = 1'b0; m_stop = 1'b0;
        m_sym = 0; m_frame = 0; m_lvl = 0;
    endtask

    task automatic model_start();
        m_sym = 0; m_frame = 0; m_stop = 1'b0; m_run = 1'b1; m_lvl = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cfg_ready"}, o_cfg_ready, 1);
        chk({tag, "_ss"}, o_map_index_ss, 1);
        chk({tag, "_M"}, o_map_index_M, 0);
        chk({tag, "_enable"}, o_map_enable, 0);
        chk({tag, "_ready_frame"}, o_map_ready_frame, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_frame_cnt"}, o_frame_cnt, 0);
        chk({tag, "_underrun"}, o_underrun, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_cfg_err"}, o_cfg_err, 0);
    endtask

    task automatic cfg_word(input bit [2:0] md, input bit [3:0] s, input int nf);
        bit legal;
        legal = (md == 3'd1) || (md == 3'd2) || (md == 3'd4) || (md == 3'd6);
        i_cfg_valid = 1'b1; i_cfg_mod = md; i_cfg_ss = s; i_cfg_nframes = 16'(nf);
        tick();
        i_cfg_valid = 1'b0;
        if (!legal) exp_err.push_back(int'(m_mod));
        else if (m_run) begin
            m_shd = 1'b1; m_shd_mod = md; m_shd_ss = (s == 0) ? 4'd1 : s; m_shd_nf = nf;
        end else begin
            m_mod = md; m_ss = (s == 0) ? 4'd1 : s; m_nf = nf;
        end
    endtask

    task automatic pulse_stop();
        i_stop = 1'b1; tick(); i_stop = 1'b0;
        m_stop = 1'b1;
    endtask

    // One mapper symbol: a few idle cycles, then the end-of-symbol strobe with a new level.
    task automatic do_sym(input int lvl, output bit f);
        sym_t e;
        f = 1'b0;
        e.rf = (m_sym >= NP) && (m_lvl >= TH);
        e.mod = m_mod; e.ss = m_ss;
        repeat ($urandom_range(1, 3)) tick();
        exp_sym.push_back(e);
        i_buf_level = LW'(lvl); i_map_oeop = 1'b1;
        tick();
        i_map_oeop = 1'b0;
        m_lvl = lvl;
        if (m_sym == FS - 1) begin
            m_sym = 0;
            if (m_frame < 65535) m_frame++;
            if (m_stop || (m_nf != 0 && m_frame == m_nf)) begin
                f = 1'b1; m_run = 1'b0;
                exp_done.push_back(m_frame);
            end
            if (m_shd) begin
                m_mod = m_shd_mod; m_ss = m_shd_ss; m_nf = m_shd_nf; m_shd = 1'b0;
            end
        end else m_sym++;
    endtask

    task automatic start_run();
        int n;
        n = 0;
        i_buf_level = LW'(200); i_start = 1'b1; tick(); i_start = 1'b0;
        model_start();
        while (!o_map_enable && n < 10) begin tick(); n++; end
        chk("enable_rise", o_map_enable, 1);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (o_busy && n < 8) begin tick(); n++; end
        chk(nm, o_busy, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_map_enable && i_map_oeop) begin
                checks++;
                if (exp_sym.size() == 0) begin
                    errors++;
                    $display("FAIL sym_unexpected: symbol end with no expectation queued");
                end else begin
                    mon_e = exp_sym.pop_front();
                    if (o_map_ready_frame != mon_e.rf || o_map_index_M != mon_e.mod ||
                        o_map_index_ss != mon_e.ss) begin
                        errors++;
                        $display("FAIL sym: got rf=%0d M=%0d ss=%0d, expected rf=%0d M=%0d ss=%0d",
                                 o_map_ready_frame, o_map_index_M, o_map_index_ss,
                                 mon_e.rf, mon_e.mod, mon_e.ss);
                    end
                end
            end
            if (o_done) begin
                checks++;
                if (exp_done.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: frame_cnt=%0d", o_frame_cnt);
                end else if (int'(o_frame_cnt) != exp_done[0]) begin
                    errors++;
                    $display("FAIL done_frame_cnt: got %0d, expected %0d", o_frame_cnt, exp_done[0]);
                    void'(exp_done.pop_front());
                end else void'(exp_done.pop_front());
            end
            if (o_cfg_err) begin
                checks++;
                if (exp_err.size() == 0) begin
                    errors++;
                    $display("FAIL cfg_err_unexpected: M=%0d", o_map_index_M);
                end else if (int'(o_map_index_M) != exp_err[0]) begin
                    errors++;
                    $display("FAIL cfg_err_active_M: got %0d, expected %0d", o_map_index_M, exp_err[0]);
                    void'(exp_err.pop_front());
                end else void'(exp_err.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_cfg_valid = 1'b0; i_cfg_mod = '0; i_cfg_ss = '0; i_cfg_nframes = '0;
        i_start = 1'b0; i_stop = 1'b0; i_buf_level = LW'(200); i_map_oeop = 1'b0; i_map_req = 1'b0;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        chk_reset("reset");

        // Single frame, full buffer: 2 preamble + 48 data symbols, then done with frame_cnt=1.
        cfg_word(3'd2, 4'd1, 1);
        chk("cfg_ready_drop", o_cfg_ready, 0);
        tick();
        chk("cfg_idle_apply", o_map_index_M, 2);
        chk("cfg_ready_back", o_cfg_ready, 1);
        start_run();
        fin = 1'b0;
        for (int i = 0; i < 60 && !fin; i++) do_sym(200, fin);
        chk("single_frame_fin", fin, 1);
        wait_idle("single_frame_idle");
        chk("single_frame_cnt", o_frame_cnt, 1);

        // Continuous run: mid-frame reconfig, low-buffer symbol, underrun, stop in frame 3.
        cfg_word(3'd2, 4'd1, 0);
        tick();
        start_run();
        fin = 1'b0;
        for (int i = 0; i < 300 && !fin; i++) begin
            do_sym((i == 15) ? 10 : 200, fin);
            if (i == 9) begin
                cfg_word(3'd6, 4'd2, 0);
                chk("cfg_ready_held", o_cfg_ready, 0);
            end
            if (i == 17) begin
                i_buf_level = '0; i_map_req = 1'b1; tick();
                i_map_req = 1'b0; i_buf_level = LW'(200);
                chk("underrun_set", o_underrun, 1);
            end
            if (i == 49) chk("cfg_ready_after_frame", o_cfg_ready, 1);
            if (i == 3 * FS + 19) pulse_stop();
        end
        chk("stop_fin", fin, 1);
        wait_idle("stop_idle");
        chk("stop_frame_cnt", o_frame_cnt, 4);
        chk("underrun_sticky", o_underrun, 1);

        // Start gated on buffer level in ARM; random levels afterwards.
        cfg_word(3'd4, 4'd0, 1);
        tick();
        i_buf_level = LW'(50); i_start = 1'b1; tick(); i_start = 1'b0;
        model_start();
        repeat (5) tick();
        chk("arm_busy", o_busy, 1);
        chk("arm_enable", o_map_enable, 0);
        chk("underrun_cleared", o_underrun, 0);
        i_buf_level = LW'(100);
        repeat (2) tick();
        chk("arm_release", o_map_enable, 1);
        fin = 1'b0;
        for (int i = 0; i < 60 && !fin; i++) do_sym($urandom_range(0, 300), fin);
        chk("arm_run_fin", fin, 1);
        wait_idle("arm_run_idle");

        // Start and stop together: start wins; then stop in ARM goes straight to IDLE.
        i_buf_level = LW'(50); i_start = 1'b1; i_stop = 1'b1; tick();
        i_start = 1'b0; i_stop = 1'b0;
        chk("start_over_stop", o_busy, 1);
        repeat (2) tick();
        exp_done.push_back(0);
        pulse_stop();
        wait_idle("arm_stop_idle");
        chk("arm_stop_enable", o_map_enable, 0);

        // Randomized short bursts.
        for (int r = 0; r < 3; r++) begin
            bit [2:0] md;
            int nf;
            case ($urandom_range(0, 3))
                0: md = 3'd1;
                1: md = 3'd2;
                2: md = 3'd4;
                default: md = 3'd6;
            endcase
            nf = $urandom_range(1, 2);
            cfg_word(md, 4'($urandom_range(0, 15)), nf);
            tick();
            start_run();
            fin = 1'b0;
            for (int i = 0; i < 2 * FS + 10 && !fin; i++) do_sym($urandom_range(0, 300), fin);
            chk("rand_fin", fin, 1);
            wait_idle("rand_idle");
            chk("rand_frame_cnt", o_frame_cnt, nf);
        end

        // Illegal modulation is dropped; then reset in the middle of DATA.
        cfg_word(3'd5, 4'd3, 0);
        chk("bad_cfg_ready", o_cfg_ready, 1);
        tick();
        chk("bad_cfg_M", o_map_index_M, int'(m_mod));
        cfg_word(3'd1, 4'd2, 0);
        tick();
        start_run();
        for (int i = 0; i < 6; i++) do_sym(200, fin);
        chk("pre_rst_ready_frame", o_map_ready_frame, 1);
        rst = 1'b1;
        tick();
        chk_reset("rst_mid");
        tick();
        rst = 1'b0;
        model_reset();
        repeat (3) tick();

        chk("sym_queue_empty", exp_sym.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        chk("err_queue_empty", exp_err.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
